// File: rtl/tone_decoder.sv
// tone_decoder: measures the period of an external square wave in clock
// cycles, scans the notes ROM for the lowest entry within TOL clocks of that
// period and commits the note once STABLE_CNT consecutive searches agree.
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   audio_i         asynchronous square-wave input
//   rom_index_o     notes ROM address (0 outside a search)
//   rom_divider_i   ROM divider for rom_index_o (combinational)
//   period_o        last captured period; period_valid_o pulses on update
//   note_index_o    committed note; note_valid_o level, note_strb_o pulse on change
//   busy_o          high while searching the ROM
module tone_decoder #(
  parameter int unsigned BW         = 16,
  parameter int unsigned IDX_BW     = 6,
  parameter int unsigned NOTES      = 64,
  parameter int unsigned TOL        = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              audio_i,
  output logic [IDX_BW-1:0] rom_index_o,
  input  logic [BW-1:0]     rom_divider_i,
  output logic [BW-1:0]     period_o,
  output logic              period_valid_o,
  output logic [IDX_BW-1:0] note_index_o,
  output logic              note_valid_o,
  output logic              note_strb_o,
  output logic              busy_o
);

  localparam int unsigned   MW       = 4;
  localparam logic [BW-1:0] CNT_MAX  = '1;
  localparam logic [BW:0]   TOL_EXT  = (BW+1)'(TOL);
  localparam logic [MW-1:0] STABLE   = MW'(STABLE_CNT);
  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(NOTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_RESULT} state_t;

  state_t            state, state_nxt;
  logic              sync1, sync2, prev;
  logic              rise, timeout, armed;
  logic [BW-1:0]     cnt, target;
  logic [IDX_BW-1:0] cand, prev_cand;
  logic              hit, prev_hit, discard;
  logic [MW-1:0]     mcnt, mcnt_upd;
  logic              commit, match, last_idx;
  logic [BW:0]       rom_ext, tgt_ext, diff;

  assign rise    = sync2 & ~prev;
  // A rise in the saturation cycle takes priority over the timeout.
  assign timeout = armed && (cnt == CNT_MAX) && !rise;

  // Synchronizer, edge detect, period counter and capture.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1          <= 1'b0;
      sync2          <= 1'b0;
      prev           <= 1'b0;
      cnt            <= '0;
      armed          <= 1'b0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
    end else begin
      sync1          <= audio_i;
      sync2          <= sync1;
      prev           <= sync2;
      period_valid_o <= 1'b0;
      if (rise) begin
        cnt   <= BW'(1);
        armed <= 1'b1;
        if (armed) begin
          period_o       <= cnt;
          period_valid_o <= 1'b1;
        end
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + BW'(1);
        if (timeout) armed <= 1'b0;
      end
    end
  end

  // Distance computed one bit wider so the subtraction never wraps.
  always_comb begin
    rom_ext  = {1'b0, rom_divider_i};
    tgt_ext  = {1'b0, target};
    diff     = (rom_ext >= tgt_ext) ? (rom_ext - tgt_ext) : (tgt_ext - rom_ext);
    match    = (rom_divider_i != '0) && (diff <= TOL_EXT);
    last_idx = (rom_index_o == LAST_IDX);
  end

  // Next state plus the stability counter update used in RESULT.
  always_comb begin
    state_nxt = state;
    mcnt_upd  = MW'(1);
    commit    = 1'b0;
    if ({hit, cand} == {prev_hit, prev_cand})
      mcnt_upd = (mcnt >= STABLE) ? STABLE : (mcnt + MW'(1));
    commit = (mcnt_upd == STABLE);
    unique case (state)
      S_IDLE:   if (period_valid_o) state_nxt = S_SEARCH;
      S_SEARCH: if (match || last_idx) state_nxt = S_RESULT;
      S_RESULT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Search datapath, debounce and committed note outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rom_index_o  <= '0;
      target       <= '0;
      cand         <= '0;
      hit          <= 1'b0;
      prev_cand    <= '0;
      prev_hit     <= 1'b0;
      mcnt         <= '0;
      discard      <= 1'b0;
      note_index_o <= '0;
      note_valid_o <= 1'b0;
      note_strb_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      note_strb_o <= 1'b0;
      busy_o      <= (state_nxt == S_SEARCH);
      unique case (state)
        S_IDLE: begin
          if (period_valid_o) begin
            target      <= period_o;
            rom_index_o <= '0;
            discard     <= 1'b0;
          end
        end
        S_SEARCH: begin
          // rom_index_o returns to 0 as soon as the scan ends.
          if (match) begin
            cand        <= rom_index_o;
            hit         <= 1'b1;
            rom_index_o <= '0;
          end else if (last_idx) begin
            hit         <= 1'b0;
            rom_index_o <= '0;
          end else begin
            rom_index_o <= rom_index_o + IDX_BW'(1);
          end
        end
        S_RESULT: begin
          if (!discard && !timeout) begin
            prev_hit  <= hit;
            prev_cand <= cand;
            mcnt      <= mcnt_upd;
            if (commit) begin
              if (hit) begin
                note_index_o <= cand;
                note_valid_o <= 1'b1;
                note_strb_o  <= !note_valid_o || (note_index_o != cand);
              end else begin
                note_valid_o <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
      // Loss of signal drops the note silently and voids a running search.
      if (timeout) begin
        note_valid_o <= 1'b0;
        note_strb_o  <= 1'b0;
        mcnt         <= '0;
        if (state == S_SEARCH) discard <= 1'b1;
      end
    end
  end

endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
- Receive-side counterpart of the PWM tone generator: takes an external square-wave audio input, measures its period in clock cycles, and maps that period back to a note index.
- The mapping is found by sequentially scanning the existing notes ROM, which is driven combinationally through rom_index_o / rom_divider_i.
- Sits beside the sound generator; used for loopback self-test and tone recognition. Reports a debounced note index with valid and change strobes.

Parameters:
- BW, 16, period counter / ROM divider width.
- IDX_BW, 6, note index width.
- NOTES, 64, number of ROM entries scanned (indices 0..NOTES-1).
- TOL, 4, max absolute difference in clocks between measured period and ROM divider for a match.
- STABLE_CNT, 3, number of consecutive identical search results required to commit; legal range 1..15.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- audio_i  in  1  asynchronous square-wave input.
- rom_index_o  out  IDX_BW  index presented to the notes ROM.
- rom_divider_i  in  BW  divider value returned combinationally by the ROM for rom_index_o.
- period_o  out  BW  last captured period in clocks.
- period_valid_o  out  1  one-cycle pulse when period_o is updated.
- note_index_o  out  IDX_BW  committed note index.
- note_valid_o  out  1  level; note_index_o is meaningful.
- note_strb_o  out  1  one-cycle pulse when the committed note changes or becomes valid.
- busy_o  out  1  high while the FSM is in SEARCH.

Behaviour:
- Reset (async, rst_n_i=0):
  - All outputs and registers go to 0; FSM goes to IDLE; detector is disarmed.
  - This holds mid-search as well: the search is aborted, no partial result is kept, and rom_index_o returns to 0.
- Input path:
  - 2-FF synchronizer with reset value 0, followed by a prev register.
  - rise is asserted in the cycle where sync2=1 and prev=0. Total latency from an audio_i edge to rise is 2-3 clocks.
- Period counter (BW bits):
  - On rise, cnt is loaded with 1; otherwise cnt increments, saturating at 2^BW-1.
  - On rise while armed: period_o <= cnt and period_valid_o pulses. A square wave with period P clocks gives period_o=P.
  - The first rise after reset or after a timeout only sets armed; there is no period_valid_o pulse.
- Timeout: when cnt reaches 2^BW-1 while armed:
  - armed is cleared, note_valid_o <= 0, and the match counter is cleared.
  - No note_strb_o is issued.
  - A search already in progress completes, but its result is discarded.
- FSM states IDLE, SEARCH, RESULT:
  - IDLE: rom_index_o=0. On period_valid_o, latch target <= captured period, idx <= 0, and go to SEARCH.
  - SEARCH: rom_index_o=idx.
    - A match means rom_divider_i != 0 and |rom_divider_i - target| <= TOL, computed in BW+1 bits with no wrap.
    - On a match: cand <= idx, hit <= 1, go to RESULT.
    - On no match with idx==NOTES-1: hit <= 0, go to RESULT. Otherwise idx++.
    - The lowest matching index wins. Worst-case duration is NOTES cycles.
  - RESULT (1 cycle), then return to IDLE:
    - If {hit, cand} equals the previous result, mcnt++ (saturating at STABLE_CNT); otherwise mcnt <= 1. Then store the current result as the previous result.
    - When mcnt reaches STABLE_CNT with hit=1: note_index_o <= cand, note_valid_o <= 1, and note_strb_o pulses if note_valid_o was 0 or note_index_o differs.
    - When mcnt reaches STABLE_CNT with hit=0: note_valid_o <= 0, no strobe.
- Periods captured while in SEARCH or RESULT still update period_o and pulse period_valid_o, but they do not start a search (dropped).
- A rise that coincides with a timeout cycle: the rise wins (cnt <= 1, armed stays/set), and no timeout is taken.
- busy_o = (state==SEARCH).

Test Plan:
- Reset mid-operation: assert rst_n_i=0 during SEARCH at idx=17 -> next cycle all outputs 0, rom_index_o=0, busy_o=0; first rise after release produces no period_valid_o.
- Lock: bench ROM with divider[10]=1000 and all other entries distant; audio_i period 1000 (500 high / 500 low) -> period_o=1000 on each rise after the first; after the 3rd search result note_index_o=10, note_valid_o=1, exactly one note_strb_o; busy_o high for 11 cycles per search.
- Tolerance edge: period 1004 -> still index 10 with no extra strobe; period 1005 -> three no-match results, then note_valid_o=0 and no strobe.
- Note change: switch to period 1500 with divider[20]=1500 -> note_index_o=20 after 3 results, one note_strb_o; divider[5]=0 (rest) with target 0 is never matched.
- Timeout: hold audio_i high after lock -> 65535 clocks after the last rise note_valid_o=0; the next rise only arms, and the second rise gives period_valid_o.
- Tie and duplicates: divider[3]=998 and divider[4]=1001, target 1000 -> cand=3; a period arriving during SEARCH updates period_o but the search target is unchanged.
